// File: rtl/sync_pkg.sv
// Shared definitions for the stable-value capture block.
//   DATA_W_DEF / STABLE_CYCLES_DEF / FIFO_DEPTH_DEF : default parameter values
//   CNT_W  : run counter width (holds STABLE_CYCLES-1 for any legal setting)
//   DROP_W : width of the saturating drop counter
//   sat_inc: increment that sticks at all-ones
package sync_pkg;

    localparam int DATA_W_DEF        = 4;
    localparam int STABLE_CYCLES_DEF = 3;
    localparam int FIFO_DEPTH_DEF    = 4;
    localparam int CNT_W             = $clog2(16);
    localparam int DROP_W            = 8;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/sync_stable_capture_if.sv
// Output stream of the stable-value capture block.
//   out_valid : producer has a value on out_data
//   out_ready : consumer accepts out_data this cycle
//   out_data  : value being offered
// Handshake: a transfer happens on every rising clk_b edge where
// out_valid && out_ready. While out_valid is high, out_data is held until that
// transfer; out_valid never depends combinationally on out_ready.
interface sync_stable_capture_if
    import sync_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO for accepted values.
//   clk_b, rst_b : clock, asynchronous active-low reset
//   push/push_data : write request; ignored when full unless a pop frees a slot
//   pop            : read request; ignored when empty
//   full, empty    : occupancy flags
//   head           : oldest entry (valid when !empty)
// Pointers carry one extra bit so full and empty are distinguishable when the
// index bits match.
module sync_fifo
    import sync_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk_b,
    input  logic              rst_b,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sync_stable_capture.sv
// Accepts a multi-bit synchronized value only after it has been sampled
// unchanged on STABLE_CYCLES consecutive clk_b edges, queues each newly
// accepted value for a valid/ready consumer, and counts values lost to
// overflow.
//   clk_b, rst_b  : clock, asynchronous active-low reset
//   sync_in       : value from the double-flop synchronizer
//   clr_ovf       : clears overflow and drop_count
//   out_if        : valid/ready output stream (master side)
//   stable_value  : last accepted value
//   stable_flag   : sync_in matches a completed stable run
//   drop_count    : saturating count of dropped pushes
//   overflow      : sticky, at least one push dropped
module sync_stable_capture
    import sync_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                  clk_b,
    input  logic                  rst_b,
    input  logic [DATA_W-1:0]     sync_in,
    input  logic                  clr_ovf,
    sync_stable_capture_if.master out_if,
    output logic [DATA_W-1:0]     stable_value,
    output logic                  stable_flag,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  overflow
);

    // cnt counts equal samples after the first one of a run, so the run is
    // complete once cnt reaches STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 2);

    logic [DATA_W-1:0] prev;
    logic [CNT_W-1:0]  cnt;
    logic              same;
    logic              accept;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign same        = (sync_in == prev);
    // Fires only on the edge that completes the run; cnt saturates afterwards.
    // Re-accepting the current stable value would only create a duplicate.
    assign accept      = same && (cnt == CNT_ACC) && (sync_in != stable_value);
    assign stable_flag = same && (cnt == CNT_MAX);
    assign pop         = out_if.out_valid && out_if.out_ready;
    assign drop        = accept && fifo_full && !pop;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_head;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_b     (clk_b),
        .rst_b     (rst_b),
        .push      (accept),
        .push_data (sync_in),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Run filter: any change, including a return to an older value, restarts.
    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            prev         <= '0;
            cnt          <= '0;
            stable_value <= '0;
        end else begin
            prev <= sync_in;
            if (same) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            if (accept) begin
                stable_value <= sync_in;
            end
        end
    end

    // A drop on the clearing edge still counts, so the clear never hides it.
    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_ovf) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc(drop_count);
        end
    end

endmodule
